// File: rtl/uart_rx_if.sv
// Receive-side word handshake of the UART receiver.
// The master (the receiver) presents a word plus per-frame error flags and
// a sticky overrun flag. The slave (the consumer) answers with i_ready.
interface uart_rx_if #(
  parameter int G_WORD_WIDTH = 8
);
  logic [G_WORD_WIDTH-1:0] o_data;
  logic                    o_valid;
  logic                    i_ready;
  logic                    o_parity_err;
  logic                    o_frame_err;
  logic                    o_overrun;

  modport master (
    output o_data, o_valid, o_parity_err, o_frame_err, o_overrun,
    input  i_ready
  );

  modport slave (
    input  o_data, o_valid, o_parity_err, o_frame_err, o_overrun,
    output i_ready
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: start, G_WORD_WIDTH data bits (LSB first), parity, stop.
// The line is oversampled G_OVERSAMPLE times per bit using a free-running tick.
// Optional build macro UART_RX_MAJORITY_EN selects the bit value as the 2-of-3
// majority of the samples at ticks mid-1, mid and mid+1. Without the macro, the
// single sample at tick mid is used. Each bit is decided on tick mid+1 in both
// builds, so frame timing does not depend on the macro.
module uart_rx #(
  parameter int   G_SYS_CLK     = 40000000,
  parameter int   G_BAUD        = 256000,
  parameter int   G_OVERSAMPLE  = 16,
  parameter int   G_WORD_WIDTH  = 8,
  parameter logic G_PARITY_TYPE = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_rx,
  output logic         o_busy,
  uart_rx_if.master    m_bus
);
  localparam int DIV   = G_SYS_CLK / (G_BAUD * G_OVERSAMPLE);
  localparam int MID   = G_OVERSAMPLE / 2;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TCK_W = $clog2(G_OVERSAMPLE);
  localparam int BIT_W = $clog2(G_WORD_WIDTH + 1);

  generate
    if (DIV < 1) begin : g_div_check
      $error("uart_rx: G_SYS_CLK/(G_BAUD*G_OVERSAMPLE) must be at least 1");
    end
    if ((G_OVERSAMPLE < 4) || ((G_OVERSAMPLE % 2) != 0)) begin : g_os_check
      $error("uart_rx: G_OVERSAMPLE must be even and at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} t_state;

  logic                    r_rx_meta, r_rx_sync;
  logic [DIV_W-1:0]        r_div_cnt;
  logic                    r_tick;
  t_state                  r_state, w_state_next;
  logic [TCK_W-1:0]        r_tick_cnt, w_tick_cnt_next;
  logic [BIT_W-1:0]        r_bit_cnt, w_bit_cnt_next;
  logic [G_WORD_WIDTH-1:0] r_shift, w_shift_next;
  logic                    r_par, w_par_next;
  logic                    r_perr_pend, w_perr_pend_next;
  logic                    w_done;
  logic                    w_line;
  logic                    w_bit;

  assign w_line = r_rx_sync;
  assign o_busy = (r_state != S_IDLE);

  // Two-flop synchronizer; resets to the idle line level so no false start.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Free-running oversample tick, one clock wide every DIV clocks.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else if (r_div_cnt == DIV_W'(DIV - 1)) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b1;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
      r_tick    <= 1'b0;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_samp;

  // Keep the samples from the two previous ticks (mid-1 and mid at decision time).
  always_ff @(posedge i_clk) begin
    if (r_tick) r_samp <= {r_samp[0], w_line};
  end

  assign w_bit = (r_samp[1] & r_samp[0]) | (r_samp[1] & w_line) | (r_samp[0] & w_line);
`else
  logic r_samp;

  // Keep the sample from the previous tick (mid at decision time).
  always_ff @(posedge i_clk) begin
    if (r_tick) r_samp <= w_line;
  end

  assign w_bit = r_samp;
`endif

  // FSM state, counters and frame accumulators.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_tick_cnt <= w_tick_cnt_next;
      r_bit_cnt  <= w_bit_cnt_next;
    end
    r_shift     <= w_shift_next;
    r_par       <= w_par_next;
    r_perr_pend <= w_perr_pend_next;
  end

  // Next-state logic; everything advances only on ticks, bits decided at mid+1.
  always_comb begin
    w_state_next     = r_state;
    w_tick_cnt_next  = r_tick_cnt;
    w_bit_cnt_next   = r_bit_cnt;
    w_shift_next     = r_shift;
    w_par_next       = r_par;
    w_perr_pend_next = r_perr_pend;
    w_done           = 1'b0;
    if (r_tick) begin
      case (r_state)
        S_IDLE: begin
          if (!w_line) begin
            w_state_next    = S_START;
            w_tick_cnt_next = '0;
          end
        end
        S_START: begin
          if (r_tick_cnt == TCK_W'(MID)) begin
            w_tick_cnt_next = '0;
            w_bit_cnt_next  = '0;
            w_par_next      = 1'b0;
            w_state_next    = w_bit ? S_IDLE : S_DATA;
          end else begin
            w_tick_cnt_next = r_tick_cnt + TCK_W'(1);
          end
        end
        S_DATA: begin
          if (r_tick_cnt == TCK_W'(G_OVERSAMPLE - 1)) begin
            w_tick_cnt_next = '0;
            w_shift_next    = {w_bit, r_shift[G_WORD_WIDTH-1:1]};
            w_par_next      = r_par ^ w_bit;
            if (r_bit_cnt == BIT_W'(G_WORD_WIDTH - 1)) begin
              w_state_next = S_PARITY;
            end else begin
              w_bit_cnt_next = r_bit_cnt + BIT_W'(1);
            end
          end else begin
            w_tick_cnt_next = r_tick_cnt + TCK_W'(1);
          end
        end
        S_PARITY: begin
          if (r_tick_cnt == TCK_W'(G_OVERSAMPLE - 1)) begin
            w_tick_cnt_next  = '0;
            w_perr_pend_next = ((r_par ^ w_bit) != G_PARITY_TYPE);
            w_state_next     = S_STOP;
          end else begin
            w_tick_cnt_next = r_tick_cnt + TCK_W'(1);
          end
        end
        S_STOP: begin
          if (r_tick_cnt == TCK_W'(G_OVERSAMPLE - 1)) begin
            w_tick_cnt_next = '0;
            w_done          = 1'b1;
            w_state_next    = w_bit ? S_IDLE : S_BREAK;
          end else begin
            w_tick_cnt_next = r_tick_cnt + TCK_W'(1);
          end
        end
        S_BREAK: begin
          if (w_line) w_state_next = S_IDLE;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Output word register with valid/ready handshake and sticky overrun.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      m_bus.o_data       <= '0;
      m_bus.o_valid      <= 1'b0;
      m_bus.o_parity_err <= 1'b0;
      m_bus.o_frame_err  <= 1'b0;
      m_bus.o_overrun    <= 1'b0;
    end else if (w_done && (!m_bus.o_valid || m_bus.i_ready)) begin
      m_bus.o_data       <= r_shift;
      m_bus.o_valid      <= 1'b1;
      m_bus.o_parity_err <= r_perr_pend;
      m_bus.o_frame_err  <= ~w_bit;
      m_bus.o_overrun    <= 1'b0;
    end else if (w_done) begin
      m_bus.o_overrun    <= 1'b1;
    end else if (m_bus.o_valid && m_bus.i_ready) begin
      m_bus.o_valid      <= 1'b0;
      m_bus.o_overrun    <= 1'b0;
    end
  end
endmodule
